// File: rtl/multdiv_pkg.sv
// Shared definitions for the multiply/divide sequencing front-end:
// FSM state encoding, default iteration counts and data width.
package multdiv_pkg;
    localparam int DATA_W          = 32;
    localparam int MULT_CYCLES_DEF = 17;
    localparam int DIV_CYCLES_DEF  = 33;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MULT = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;
endpackage

// File: rtl/multdiv_if.sv
// Processor-facing request/result bundle of the multiply/divide front-end.
// master = issuing side, slave = multdiv_ctrl.
interface multdiv_if;
    import multdiv_pkg::*;

    logic              ctrl_MULT;
    logic              ctrl_DIV;
    logic [DATA_W-1:0] data_operandA;
    logic [DATA_W-1:0] data_operandB;
    logic [DATA_W-1:0] data_result;
    logic              data_exception;
    logic              data_resultRDY;
    logic              busy;

    modport master (
        output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
        input  data_result, data_exception, data_resultRDY, busy
    );

    modport slave (
        input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
        output data_result, data_exception, data_resultRDY, busy
    );
endinterface

// File: rtl/multdiv_counter.sv
// Shared iteration counter for the Booth multiplier and restoring divider
// stages; clear has priority over enable.
module multdiv_counter
    import multdiv_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              enable,
    output logic [DATA_W-1:0] count
);
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + DATA_W'(1);
        end
    end
endmodule

// File: rtl/multdiv_ctrl.sv
// Sequencing front-end for the iterative multiply/divide unit.
// Optional macro MULTDIV_STICKY_RESULT_EN: result/exception hold the last captured value.
module multdiv_ctrl
    import multdiv_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    multdiv_if.slave          bus,
    output logic [DATA_W-1:0] count,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    input  logic [DATA_W-1:0] mult_product,
    input  logic              mult_overflow,
    input  logic [DATA_W-1:0] div_quotient
);
    state_t            state;
    logic [DATA_W-1:0] res_cap;
    logic              exc_cap;
    logic              start;
    logic              mult_term;
    logic              div_term;
    logic              cnt_en;

    assign start     = bus.ctrl_MULT | bus.ctrl_DIV;
    assign mult_term = (state == MULT) && (count == DATA_W'(MULT_CYCLES));
    assign div_term  = (state == DIV)  && (count == DATA_W'(DIV_CYCLES));
    // Count freezes on the terminal value so it holds through DONE and IDLE.
    assign cnt_en    = ((state == MULT) && !mult_term) || ((state == DIV) && !div_term);

    multdiv_counter u_counter (
        .clk    (clk),
        .reset  (reset),
        .clear  (start),
        .enable (cnt_en),
        .count  (count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= IDLE;
            op_a               <= '0;
            op_b               <= '0;
            bus.data_result    <= '0;
            bus.data_exception <= 1'b0;
            bus.data_resultRDY <= 1'b0;
            bus.busy           <= 1'b0;
        end else begin
            // Result presentation lags the capture by one cycle (registered outputs).
            bus.data_resultRDY <= (state == DONE);
`ifdef MULTDIV_STICKY_RESULT_EN
            if (state == DONE) begin
                bus.data_result    <= res_cap;
                bus.data_exception <= exc_cap;
            end
`else
            if (state == DONE) begin
                bus.data_result    <= res_cap;
                bus.data_exception <= exc_cap;
            end else begin
                bus.data_result    <= '0;
                bus.data_exception <= 1'b0;
            end
`endif
            case (state)
                MULT: begin
                    if (mult_term) begin
                        res_cap  <= mult_product;
                        exc_cap  <= mult_overflow;
                        state    <= DONE;
                        bus.busy <= 1'b0;
                    end
                end
                DIV: begin
                    if (div_term) begin
                        res_cap  <= (op_b == '0) ? '0 : div_quotient;
                        exc_cap  <= (op_b == '0);
                        state    <= DONE;
                        bus.busy <= 1'b0;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
            // A start overrides whatever the current state decided, aborting any op in flight.
            if (start) begin
                op_a     <= bus.data_operandA;
                op_b     <= bus.data_operandB;
                state    <= bus.ctrl_MULT ? MULT : DIV;
                bus.busy <= 1'b1;
            end
        end
    end
endmodule

// File: doc/multdiv_ctrl.md
Name: multdiv_ctrl

Overview:
- Sequencing front-end for the iterative multiply/divide unit.
- Accepts a one-cycle ctrl_MULT or ctrl_DIV pulse and latches both operands.
- Drives the shared iteration count and held operands to the radix-4 Booth multiplier stage and the restoring divider stage.
- Samples the selected stage's result and exception at the terminal count and raises data_resultRDY for exactly one cycle.

Parameters:
- MULT_CYCLES, 17, count value at which the multiplier result is sampled (1 load cycle + 16 Booth radix-4 steps).
- DIV_CYCLES, 33, count value at which the divider result is sampled (1 load cycle + 32 steps).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- ctrl_MULT  in  1  start-multiply pulse.
- ctrl_DIV  in  1  start-divide pulse.
- data_operandA  in  32  multiplicand / dividend, sampled on start.
- data_operandB  in  32  multiplier / divisor, sampled on start.
- count  out  32  iteration count to both stages; bits [31:5] carry the full count, not zero-extended.
- op_a  out  32  held operandA to stages.
- op_b  out  32  held operandB to stages.
- mult_product  in  32  multiplier stage product.
- mult_overflow  in  1  multiplier stage overflow.
- div_quotient  in  32  divider stage quotient.
- data_result  out  32  captured result.
- data_exception  out  1  overflow (mult) or divide-by-zero (div).
- data_resultRDY  out  1  one-cycle result-valid strobe.
- busy  out  1  high while an operation is in flight.

Behaviour:
- Clock and reset: one clock domain, clk; reset synchronous, active-high.
- Reset values: state=IDLE; count=0; op_a=op_b=0; data_result=0; data_exception=0; data_resultRDY=0; busy=0.
- States: IDLE, MULT, DIV, DONE.
- Start:
  - On a cycle with ctrl_MULT=1, latch op_a/op_b, set count=0 and go to MULT.
  - On ctrl_DIV=1 (and ctrl_MULT=0), do the same but go to DIV.
  - Start is accepted from any state; a start while MULT/DIV is active aborts the current op and restarts with count=0 and new operands. No RDY is issued for the aborted op.
  - Simultaneous ctrl_MULT and ctrl_DIV: MULT wins.
- Count: in MULT/DIV, count increments by 1 per cycle. The stage sees count==0 on the first cycle after the start edge (its load cycle).
- MULT termination: when count==MULT_CYCLES, capture data_result=mult_product and data_exception=mult_overflow, then go to DONE.
- DIV termination: when count==DIV_CYCLES, capture data_result=div_quotient and data_exception=(op_b==0), then go to DONE.
  - Divide-by-zero forces data_result=0.
  - Divide-by-zero still runs the full DIV_CYCLES; there is no early exit.
- DONE: data_resultRDY=1 for exactly this one cycle, then go to IDLE. A start in DONE is honoured (RDY still pulses that cycle).
- Latency: start edge to RDY is MULT_CYCLES+2 cycles (mult) or DIV_CYCLES+2 cycles (div).
- busy: 1 in MULT and DIV, 0 in IDLE and DONE.
- count and operands hold their values in IDLE and DONE.
- Reset mid-operation: returns to IDLE next edge, no RDY, all outputs to reset values.
- Start and reset in the same cycle: reset wins.

Optional Feature:
- Macro: MULTDIV_STICKY_RESULT_EN.
- Defined: data_result/data_exception hold the last captured value until the next capture or reset.
- Undefined: data_result/data_exception are driven to 0 in every cycle except DONE; the captured value is visible only alongside data_resultRDY.

Decomposition:
- Shared package multdiv_pkg holds:
  - state encoding (IDLE/MULT/DIV/DONE, 2-bit);
  - MULT_CYCLES and DIV_CYCLES defaults;
  - 32-bit data-width constant.
- One natural sub-module: multdiv_counter, a 32-bit synchronous counter with clear and enable driving count.
- The FSM and result capture stay in multdiv_ctrl.

Test Plan:
- Mult pulse, A=6, B=7, mult_product stub = 42 at count 17 -> RDY high exactly at cycle 19 after start, data_result=42, data_exception=0, busy low in that cycle.
- Div pulse, A=100, B=0 -> RDY at cycle 35, data_exception=1, data_result=0.
- Mult start, then ctrl_DIV at count=5 with A=9, B=3 -> no RDY for the mult; count restarts at 0; RDY at 35 cycles after the second pulse with the quotient stub 3.
- ctrl_MULT and ctrl_DIV together -> state MULT, RDY after MULT_CYCLES+2.
- reset asserted at count=10 of a div -> next cycle busy=0, count=0, outputs 0, no RDY ever.
- With MULTDIV_STICKY_RESULT_EN: data_result stays 42 for 10 idle cycles after RDY. Without it: data_result=0 one cycle after RDY.
